accum_core: RTL and testbench

Parametrised accumulator-machine core for the multicore matrix-multiplication array. It generalises the single 16-bit processor in three ways: configurable data/address width, a configurable number of loop-index registers, and a req/ack data-memory handshake so several cores can share one arbitrated memory. It fetches 16-bit instructions, executes them through a multicycle FSM, and raises done on HALT.

---
 rtl/accum_pkg.sv | 46 ++++
 rtl/accum_alu.sv | 37 +++
 rtl/accum_core.sv | 227 ++++++++++++++++++++++
 tb/tb_accum_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator core: opcodes, IDX sub-ops,
// MISC sub-ops, ALU operations and FSM state encodings.
package accum_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LDI    = 4'h1;
    localparam logic [3:0] OP_LDM    = 4'h2;
    localparam logic [3:0] OP_STM    = 4'h3;
    localparam logic [3:0] OP_MVR    = 4'h4;
    localparam logic [3:0] OP_ADD    = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_MUL    = 4'h7;
    localparam logic [3:0] OP_SETDAR = 4'h8;
    localparam logic [3:0] OP_INCDAR = 4'h9;
    localparam logic [3:0] OP_IDX    = 4'hA;
    localparam logic [3:0] OP_JMP    = 4'hB;
    localparam logic [3:0] OP_JZ     = 4'hC;
    localparam logic [3:0] OP_JNZ    = 4'hD;
    localparam logic [3:0] OP_MISC   = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [1:0] IDX_INC  = 2'd0;
    localparam logic [1:0] IDX_CLR  = 2'd1;
    localparam logic [1:0] IDX_LOAD = 2'd2;
    localparam logic [1:0] IDX_READ = 2'd3;

    localparam logic MISC_MAC   = 1'b0;
    localparam logic MISC_GETID = 1'b1;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_MAC
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT
    } state_e;

endpackage

// File: rtl/accum_alu.sv
// Combinational arithmetic for the accumulator core.
// MAC (AC + R*I0) only exists when ACCUM_CORE_MAC_EN is defined; otherwise
// no second multiplier is built and the I0 input is ignored.
module accum_alu
    import accum_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] i0,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

`ifndef ACCUM_CORE_MAC_EN
    logic unused_i0;
    assign unused_i0 = ^i0;
`endif

    // Select the arithmetic result; all operations wrap modulo 2^DATA_W.
    always_comb begin
        result = ac;
        case (op)
            ALU_ADD: result = ac + r;
            ALU_SUB: result = ac - r;
            ALU_MUL: result = ac * r;
`ifdef ACCUM_CORE_MAC_EN
            ALU_MAC: result = ac + (r * i0);
`endif
            default: result = ac;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/accum_core.sv
// Parametrised accumulator-machine core with req/ack data-memory port.
// Optional MAC instruction enabled by defining ACCUM_CORE_MAC_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | after reset, waiting for start
// S_FETCH    | im_addr = PC presented to instruction memory
// S_DECODE   | IR <= im_rdata, PC <= PC+1
// S_EXEC     | execute; LDM/STM issue a memory request, HALT stops
// S_MEM_WAIT | dm_req held until dm_ack; LDM captures dm_rdata on ack
// S_HALT     | done=1, start restarts from PC=0 keeping other registers
module accum_core
    import accum_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int NUM_IDX = 4,
    parameter int CORE_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [15:0]       im_rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc_out
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   dar_q, dar_d;
    logic [DATA_W-1:0]   ac_q, ac_d;
    logic [DATA_W-1:0]   r_q, r_d;
    logic [15:0]         ir_q, ir_d;
    logic                z_q, z_d;
    logic [DATA_W-1:0]   idx_q [NUM_IDX];
    logic [DATA_W-1:0]   idx_d [NUM_IDX];
    logic                dm_req_q, dm_req_d;
    logic                dm_we_q, dm_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imm_data;
    logic [ADDR_W-1:0]   imm_addr;
    alu_op_e             alu_op;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;

    assign opcode   = ir_q[15:12];
    assign imm_data = DATA_W'(ir_q[11:0]);
    assign imm_addr = ADDR_W'(ir_q[11:0]);

    assign im_addr  = pc_q;
    assign pc_out   = pc_q;
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dar_q;
    assign dm_wdata = ac_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Map the current opcode onto an ALU operation.
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_MUL:  alu_op = ALU_MUL;
            OP_MISC: alu_op = ALU_MAC;
            default: alu_op = ALU_ADD;
        endcase
    end

    accum_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .ac     (ac_q),
        .r      (r_q),
        .i0     (idx_q[0]),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dar_d    = dar_q;
        ac_d     = ac_q;
        r_d      = r_q;
        ir_d     = ir_q;
        z_d      = z_q;
        idx_d    = idx_q;
        dm_we_d  = dm_we_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = im_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDI:    ac_d = imm_data;
                    OP_LDM: begin
                        dm_we_d = 1'b0;
                        state_d = S_MEM_WAIT;
                    end
                    OP_STM: begin
                        dm_we_d = 1'b1;
                        state_d = S_MEM_WAIT;
                    end
                    OP_MVR:    r_d = ac_q;
                    OP_ADD, OP_SUB, OP_MUL: begin
                        ac_d = alu_result;
                        z_d  = alu_zero;
                    end
                    OP_SETDAR: dar_d = ADDR_W'(ac_q);
                    OP_INCDAR: dar_d = dar_q + imm_addr;
                    OP_IDX: begin
                        // Selects beyond NUM_IDX match no register and fall through as NOP.
                        for (int i = 0; i < NUM_IDX; i++) begin
                            if (ir_q[11:10] == 2'(i)) begin
                                case (ir_q[9:8])
                                    IDX_INC:  idx_d[i] = idx_q[i] + DATA_W'(1);
                                    IDX_CLR:  idx_d[i] = '0;
                                    IDX_LOAD: idx_d[i] = ac_q;
                                    default:  ac_d     = idx_q[i];
                                endcase
                            end
                        end
                    end
                    OP_JMP:    pc_d = imm_addr;
                    OP_JZ:     if (z_q)  pc_d = imm_addr;
                    OP_JNZ:    if (!z_q) pc_d = imm_addr;
                    OP_MISC: begin
                        if (ir_q[0] == MISC_GETID) begin
                            ac_d = DATA_W'(CORE_ID);
                        end
`ifdef ACCUM_CORE_MAC_EN
                        else begin
                            ac_d = alu_result;
                            z_d  = alu_zero;
                        end
`endif
                    end
                    OP_HALT:   state_d = S_HALT;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEM_WAIT: begin
                if (dm_ack) begin
                    if (!dm_we_q) begin
                        ac_d = dm_rdata;
                        z_d  = (dm_rdata == '0);
                    end
                    dm_we_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        dm_req_d = (state_d == S_MEM_WAIT);
        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXEC)  || (state_d == S_MEM_WAIT);
        done_d   = (state_d == S_HALT);
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            dar_q    <= '0;
            ac_q     <= '0;
            r_q      <= '0;
            ir_q     <= '0;
            z_q      <= 1'b0;
            for (int i = 0; i < NUM_IDX; i++) begin
                idx_q[i] <= '0;
            end
            dm_req_q <= 1'b0;
            dm_we_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dar_q    <= dar_d;
            ac_q     <= ac_d;
            r_q      <= r_d;
            ir_q     <= ir_d;
            z_q      <= z_d;
            idx_q    <= idx_d;
            dm_req_q <= dm_req_d;
            dm_we_q  <= dm_we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_accum_core.sv
// Directed bench for accum_core: a 16-bit core (CORE_ID=3) with a scripted
// data-memory handshake, and an 8-bit core for wrap-around arithmetic.
module tb_accum_core;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        start8;

    logic [15:0] im_addr, im_rdata, pc_out;
    logic        dm_req, dm_we, dm_ack, busy, done;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;

    logic [15:0] im_addr8, im_rdata8, pc_out8;
    logic        dm_req8, dm_we8, busy8, done8;
    logic [15:0] dm_addr8;
    logic [7:0]  dm_wdata8;
    logic [7:0]  dm_rdata8;
    logic        dm_ack8;

    logic [15:0] imem  [65536];
    logic [15:0] imem8 [65536];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    accum_core #(.DATA_W(16), .ADDR_W(16), .NUM_IDX(4), .CORE_ID(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .im_addr(im_addr), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .busy(busy), .done(done), .pc_out(pc_out)
    );

    accum_core #(.DATA_W(8), .ADDR_W(16), .NUM_IDX(2), .CORE_ID(0)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .im_addr(im_addr8), .im_rdata(im_rdata8),
        .dm_req(dm_req8), .dm_we(dm_we8), .dm_addr(dm_addr8), .dm_wdata(dm_wdata8),
        .dm_rdata(dm_rdata8), .dm_ack(dm_ack8),
        .busy(busy8), .done(done8), .pc_out(pc_out8)
    );

    // Synchronous instruction memories: word valid one cycle after address.
    always @(posedge clk) begin
        im_rdata  <= imem[im_addr];
        im_rdata8 <= imem8[im_addr8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_done8(input string tag);
        int n;
        n = 0;
        while (done8 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done8, 1);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (dm_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, dm_req, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            imem[i]  = 16'hF000;
            imem8[i] = 16'hF000;
        end
        rst = 1'b1; start = 1'b0; start8 = 1'b0;
        dm_ack = 1'b0; dm_rdata = 16'h0; dm_ack8 = 1'b0; dm_rdata8 = 8'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_pc", pc_out, 16'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_we", dm_we, 0);
        chk("rst_ac", dm_wdata, 16'h0);
        chk("rst8_busy", busy8, 0);
        chk("rst8_req", dm_req8, 0);
        chk("rst8_addr", dm_addr8, 16'h0);

        // LDI 5, MVR, LDI 7, ADD, HALT
        imem[0] = 16'h1005; imem[1] = 16'h4000; imem[2] = 16'h1007;
        imem[3] = 16'h5000; imem[4] = 16'hF000;
        pulse_start();
        chk("run_busy", busy, 1);
        wait_done("add_done", cyc);
        chk("add_cycles", cyc, 15);
        chk("add_ac", dm_wdata, 16'd12);
        chk("add_z", dut.z_q, 0);
        chk("add_busy", busy, 0);
        chk("add_pc", pc_out, 16'h5);

        // LDI 3, MVR, SUB, JZ 0x010 -> taken
        imem[0] = 16'h1003; imem[1] = 16'h4000; imem[2] = 16'h6000;
        imem[3] = 16'hC010; imem[4] = 16'h1077; imem[5] = 16'hF000;
        imem[16'h10] = 16'hF000;
        pulse_start();
        wait_done("jz_done", cyc);
        chk("jz_pc", pc_out, 16'h11);
        chk("jz_z", dut.z_q, 1);
        chk("jz_ac", dm_wdata, 16'h0);

        // Same sequence with JNZ -> falls through
        imem[3] = 16'hD010;
        pulse_start();
        wait_done("jnz_done", cyc);
        chk("jnz_pc", pc_out, 16'h6);
        chk("jnz_ac", dm_wdata, 16'h77);
        chk("jnz_z", dut.z_q, 1);

        // STM with delayed ack, INCDAR, then LDM
        imem[0] = 16'h1123; imem[1] = 16'h8000; imem[2] = 16'h1055;
        imem[3] = 16'h3000; imem[4] = 16'h9002; imem[5] = 16'h2000;
        imem[6] = 16'hF000;
        pulse_start();
        wait_req("stm_req_seen");
        for (int i = 0; i < 4; i++) begin
            chk("stm_req_hold", dm_req, 1);
            chk("stm_we_hold", dm_we, 1);
            chk("stm_addr_hold", dm_addr, 16'h0123);
            chk("stm_wdata_hold", dm_wdata, 16'h0055);
            if (i == 3) dm_ack = 1'b1;
            @(negedge clk);
        end
        dm_ack = 1'b0;
        chk("stm_req_drop", dm_req, 0);
        wait_req("ldm_req_seen");
        chk("ldm_we", dm_we, 0);
        chk("ldm_addr", dm_addr, 16'h0125);
        dm_rdata = 16'h00AB;
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0;
        dm_rdata = 16'h0;
        chk("ldm_req_drop", dm_req, 0);
        wait_done("ldm_done", cyc);
        chk("ldm_ac", dm_wdata, 16'h00AB);
        chk("ldm_z", dut.z_q, 0);

        // GETID
        imem[0] = 16'hE001; imem[1] = 16'hF000;
        pulse_start();
        wait_done("getid_done", cyc);
        chk("getid_ac", dm_wdata, 16'd3);

        // IDX: I0<=9, INC, READ -> AC=10
        imem[0] = 16'h1009; imem[1] = 16'hA200; imem[2] = 16'hA000;
        imem[3] = 16'h1000; imem[4] = 16'hA300; imem[5] = 16'hF000;
        pulse_start();
        wait_done("idx_done", cyc);
        chk("idx_ac", dm_wdata, 16'h000A);

        // MAC: I0=4, R=3, Z=1 via SUB, AC=2, MAC
        imem[0] = 16'h1004; imem[1] = 16'hA200; imem[2] = 16'h1003;
        imem[3] = 16'h4000; imem[4] = 16'h6000; imem[5] = 16'h1002;
        imem[6] = 16'hE000; imem[7] = 16'hF000;
        pulse_start();
        wait_done("mac_done", cyc);
`ifdef ACCUM_CORE_MAC_EN
        chk("mac_ac", dm_wdata, 16'd14);
        chk("mac_z", dut.z_q, 0);
`else
        chk("mac_off_ac", dm_wdata, 16'd2);
        chk("mac_off_z", dut.z_q, 1);
`endif

        // 8-bit core: LDI 0xFF, MVR, ADD -> 0xFE
        imem8[0] = 16'h10FF; imem8[1] = 16'h4000; imem8[2] = 16'h5000;
        imem8[3] = 16'hF000;
        pulse_start8();
        wait_done8("w8_add_done");
        chk("w8_add_ac", dm_wdata8, 8'hFE);
        chk("w8_add_z", dut8.z_q, 0);

        // 8-bit core: 0x10 * 0x10 -> 0x00, Z=1
        imem8[0] = 16'h1010; imem8[1] = 16'h4000; imem8[2] = 16'h7000;
        imem8[3] = 16'hF000;
        pulse_start8();
        wait_done8("w8_mul_done");
        chk("w8_mul_ac", dm_wdata8, 8'h00);
        chk("w8_mul_z", dut8.z_q, 1);
        chk("w8_pc", pc_out8, 16'h4);
        chk("w8_busy", busy8, 0);

        // Reset while in MEM_WAIT with start also asserted
        imem[0] = 16'h1042; imem[1] = 16'h4000; imem[2] = 16'h8000;
        imem[3] = 16'h3000; imem[4] = 16'hF000;
        pulse_start();
        wait_req("rstmw_req_seen");
        chk("rstmw_addr_pre", dm_addr, 16'h0042);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rstmw_req", dm_req, 0);
        chk("rstmw_we", dm_we, 0);
        chk("rstmw_busy", busy, 0);
        chk("rstmw_done", done, 0);
        chk("rstmw_pc", pc_out, 16'h0);
        chk("rstmw_dar", dm_addr, 16'h0);
        chk("rstmw_ac", dm_wdata, 16'h0);
        chk("rstmw_z", dut.z_q, 0);
        repeat (2) @(negedge clk);
        chk("rstmw_idle", busy, 0);

        // R must have been cleared: ADD from AC=0 gives 0 with Z=1
        imem[0] = 16'h5000; imem[1] = 16'hF000;
        pulse_start();
        wait_done("rstmw_add_done", cyc);
        chk("rstmw_r_ac", dm_wdata, 16'h0);
        chk("rstmw_r_z", dut.z_q, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
